// File: rtl/i2s_sample_capture_if.sv
// i2s_sample_capture_if
//   Frame hand-off bundle between the I2S capture block and its consumer.
//   Ports (signals):
//     data_left, data_right  captured stereo sample, two's complement
//     sample_valid           a frame is held on data_left/data_right
//     sample_ready           consumer accepts the held frame
//     overrun                one-cycle pulse when a completed frame is dropped
//     overrun_count          8-bit saturating overrun counter, present only
//                            when I2S_CAPTURE_OVERRUN_CNT_EN is defined
//   Modports: master = capture block, slave = consumer.
interface i2s_sample_capture_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data_left;
  logic [DATA_WIDTH-1:0] data_right;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  overrun;
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
  logic [7:0]            overrun_count;

  modport master (
    output data_left, data_right, sample_valid, overrun, overrun_count,
    input  sample_ready
  );
  modport slave (
    input  data_left, data_right, sample_valid, overrun, overrun_count,
    output sample_ready
  );
`else
  modport master (
    output data_left, data_right, sample_valid, overrun,
    input  sample_ready
  );
  modport slave (
    input  data_left, data_right, sample_valid, overrun,
    output sample_ready
  );
`endif
endinterface

// File: rtl/i2s_sample_capture.sv
// i2s_sample_capture
//   Captures stereo I2S frames from an asynchronous bit clock into the
//   CLOCK_50 domain and presents them on a valid/ready hand-off.
//   Ports:
//     clock      system clock
//     reset      asynchronous active-high reset
//     i2s_bclk   asynchronous I2S bit clock
//     i2s_lrck   asynchronous word select (0 = left, 1 = right)
//     i2s_sdat   asynchronous serial data, MSB first
//     cap        i2s_sample_capture_if.master (data, valid/ready, overrun)
//   Optional: define I2S_CAPTURE_OVERRUN_CNT_EN to add cap.overrun_count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   UNLOCKED | waiting for a boundary into a left slot, nothing captured
//   LEFT     | collecting the left slot of the current frame
//   RIGHT    | collecting the right slot; left slot already held
module i2s_sample_capture #(
  parameter int DATA_WIDTH    = 24,
  parameter int MIN_SLOT_BITS = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrck,
  input  logic                 i2s_sdat,
  i2s_sample_capture_if.master cap
);
  localparam int CNT_W = $clog2(MIN_SLOT_BITS + 1);

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;
  state_t state, state_nxt;

  logic [1:0]            bclk_sync, lrck_sync, sdat_sync;
  logic                  bclk_prev, lrck_prev;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg, left_hold, out_left, out_right;
  logic                  left_valid, out_valid, overrun_q;
  logic                  bclk_rise, boundary, slot_full;
  logic                  latch_left, clear_left, frame_done, drop_frame;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      sdat_sync <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], i2s_bclk};
      lrck_sync <= {lrck_sync[0], i2s_lrck};
      sdat_sync <= {sdat_sync[0], i2s_sdat};
      bclk_prev <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign boundary  = bclk_rise & (lrck_sync[1] != lrck_prev);
  // bit_cnt saturates at MIN_SLOT_BITS, so reaching it means the slot is long enough
  assign slot_full = (bit_cnt >= CNT_W'(MIN_SLOT_BITS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_left = 1'b0;
    clear_left = 1'b0;
    frame_done = 1'b0;
    if (boundary) begin
      unique case (state)
        UNLOCKED: begin
          clear_left = 1'b1;
          if (!lrck_sync[1]) state_nxt = LEFT;
        end
        LEFT: begin
          if (!slot_full) begin
            state_nxt  = UNLOCKED;
            clear_left = 1'b1;
          end else if (lrck_sync[1]) begin
            state_nxt  = RIGHT;
            latch_left = 1'b1;
          end
        end
        RIGHT: begin
          clear_left = 1'b1;
          if (!slot_full)          state_nxt = UNLOCKED;
          else if (!lrck_sync[1]) begin
            state_nxt  = LEFT;
            frame_done = left_valid;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lrck_prev  <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      left_hold  <= '0;
      left_valid <= 1'b0;
    end else if (bclk_rise) begin
      lrck_prev <= lrck_sync[1];
      if (boundary) begin
        // the bit on the boundary edge is the previous slot's trailing bit
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else begin
        if (bit_cnt < CNT_W'(DATA_WIDTH))
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], sdat_sync[1]};
        if (!slot_full)
          bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (latch_left) begin
        left_hold  <= shift_reg;
        left_valid <= 1'b1;
      end else if (clear_left) begin
        left_valid <= 1'b0;
      end
    end
  end

  // a completed frame is dropped only when the held one is not leaving this cycle
  assign drop_frame = frame_done & out_valid & ~cap.sample_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= drop_frame;
      if (frame_done && !drop_frame) begin
        out_left  <= left_hold;
        out_right <= shift_reg;
        out_valid <= 1'b1;
      end else if (out_valid && cap.sample_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                overrun_cnt <= '0;
    else if (drop_frame && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end

  assign cap.overrun_count = overrun_cnt;
`endif

  assign cap.data_left    = out_left;
  assign cap.data_right   = out_right;
  assign cap.sample_valid = out_valid;
  assign cap.overrun      = overrun_q;
endmodule

// File: tb/tb_i2s_sample_capture.sv
`timescale 1ns/1ps
module tb_i2s_sample_capture;
  localparam int DW   = 24;
  localparam int MINB = 24;

  typedef struct {
    bit            lr;
    int            len;
    logic [DW-1:0] data;
  } slot_t;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic i2s_bclk = 1'b0;
  logic i2s_lrck = 1'b0;
  logic i2s_sdat = 1'b0;

  i2s_sample_capture_if #(.DATA_WIDTH(DW)) bus ();

  i2s_sample_capture #(.DATA_WIDTH(DW), .MIN_SLOT_BITS(MINB)) dut (
    .clock    (clock),
    .reset    (reset),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_sdat (i2s_sdat),
    .cap      (bus)
  );

  always #10 clock = ~clock;

  int tests = 0;
  int fails = 0;

  slot_t           slots[$];
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] got_q[$];
  int              ovr_cycles   = 0;
  int              valid_cycles = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.sample_valid && bus.sample_ready) got_q.push_back({bus.data_left, bus.data_right});
      if (bus.overrun)      ovr_cycles++;
      if (bus.sample_valid) valid_cycles++;
    end
  end

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: a frame is delivered for every left slot that begins on
  // a boundary (a right slot precedes it since reset), is followed by a right
  // slot, and is closed by a further slot; both slots need at least MINB data
  // edges (the first edge of each slot is the boundary edge).
  function automatic void model();
    exp_q.delete();
    for (int i = 1; i + 2 < slots.size(); i++) begin
      if (slots[i-1].lr == 1'b1 && slots[i].lr == 1'b0 && slots[i+1].lr == 1'b1 &&
          slots[i].len - 1 >= MINB && slots[i+1].len - 1 >= MINB)
        exp_q.push_back({slots[i].data, slots[i+1].data});
    end
  endfunction

  task automatic wait_half();
    repeat ($urandom_range(3, 5)) @(posedge clock);
    #5;
  endtask

  task automatic send_bit(input bit lr, input bit d);
    i2s_bclk = 1'b0;
    i2s_lrck = lr;
    i2s_sdat = d;
    wait_half();
    i2s_bclk = 1'b1;
    wait_half();
  endtask

  task automatic send_slot(input bit lr, input logic [DW-1:0] data, input int len);
    slot_t s;
    bit    b;
    s.lr   = lr;
    s.len  = len;
    s.data = data;
    slots.push_back(s);
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= DW) b = data[DW-i];
      else                   b = 1'($urandom_range(0, 1));
      send_bit(lr, b);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    i2s_bclk = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    slots.delete();
    reset = 1'b0;
  endtask

  task automatic check_frames(input string name, input int base);
    tests++;
    if (got_q.size() - base !== exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d frames, expected %0d", name, got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (base + k >= got_q.size()) begin
        fails++;
        $display("FAIL %s_frame%0d: got none, expected %h", name, k, exp_q[k]);
      end else if (got_q[base+k] !== exp_q[k]) begin
        fails++;
        $display("FAIL %s_frame%0d: got %h, expected %h", name, k, got_q[base+k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++;
    if (bus.data_left !== '0) begin fails++; $display("FAIL reset_left: got %h, expected 0", bus.data_left); end
    tests++;
    if (bus.data_right !== '0) begin fails++; $display("FAIL reset_right: got %h, expected 0", bus.data_right); end
    tests++;
    if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", bus.sample_valid); end
    tests++;
    if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b, expected 0", bus.overrun); end
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
    tests++;
    if (bus.overrun_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d, expected 0", bus.overrun_count); end
`endif
  endtask

  task automatic test_stream();
    int base, vbase, obase;
    do_reset();
    bus.sample_ready = 1'b1;
    base  = got_q.size();
    vbase = valid_cycles;
    obase = ovr_cycles;
    send_slot(1'b0, DW'($urandom), 10);
    send_slot(1'b1, DW'($urandom), 32);
    repeat (2) begin
      send_slot(1'b0, 24'h123456, 32);
      send_slot(1'b1, 24'hFEDCBA, 32);
    end
    repeat (3) begin
      send_slot(1'b0, DW'($urandom), $urandom_range(26, 40));
      send_slot(1'b1, DW'($urandom), $urandom_range(26, 40));
    end
    send_slot(1'b0, DW'($urandom), 3);
    repeat (10) @(posedge clock);
    model();
    check_frames("stream", base);
    tests++;
    if (valid_cycles - vbase !== exp_q.size()) begin
      fails++;
      $display("FAIL stream_valid_cycles: got %0d, expected %0d", valid_cycles - vbase, exp_q.size());
    end
    tests++;
    if (ovr_cycles !== obase) begin fails++; $display("FAIL stream_overrun: got %0d pulses, expected 0", ovr_cycles - obase); end
  endtask

  task automatic test_overrun();
    int base, obase;
    do_reset();
    bus.sample_ready = 1'b0;
    base  = got_q.size();
    obase = ovr_cycles;
    send_slot(1'b1, DW'($urandom), 6);
    repeat (2) begin
      send_slot(1'b0, DW'($urandom), 32);
      send_slot(1'b1, DW'($urandom), 32);
    end
    send_slot(1'b0, DW'($urandom), 3);
    repeat (10) @(posedge clock);
    model();
    @(negedge clock);
    tests++;
    if (bus.sample_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b, expected 1", bus.sample_valid); end
    tests++;
    if ({bus.data_left, bus.data_right} !== exp_q[0]) begin
      fails++;
      $display("FAIL ovr_held: got %h, expected %h", {bus.data_left, bus.data_right}, exp_q[0]);
    end
    tests++;
    if (ovr_cycles - obase !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d, expected 1", ovr_cycles - obase); end
`ifdef I2S_CAPTURE_OVERRUN_CNT_EN
    tests++;
    if (bus.overrun_count !== 8'd1) begin fails++; $display("FAIL ovr_count: got %0d, expected 1", bus.overrun_count); end
`endif
    @(posedge clock);
    #1 bus.sample_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    exp_q = exp_q[0:0];
    check_frames("ovr_drain", base);
    tests++;
    if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL ovr_valid_clear: got %b, expected 0", bus.sample_valid); end
  endtask

  task automatic test_short_slot();
    int base, vbase;
    do_reset();
    bus.sample_ready = 1'b1;
    base  = got_q.size();
    vbase = valid_cycles;
    send_slot(1'b1, DW'($urandom), 6);
    send_slot(1'b0, DW'($urandom), 32);
    send_slot(1'b1, DW'($urandom), 32);
    send_slot(1'b0, DW'($urandom), 16);
    send_slot(1'b1, DW'($urandom), 32);
    send_slot(1'b0, DW'($urandom), 32);
    send_slot(1'b1, DW'($urandom), 32);
    send_slot(1'b0, DW'($urandom), 3);
    repeat (10) @(posedge clock);
    model();
    check_frames("short", base);
    tests++;
    if (valid_cycles - vbase !== exp_q.size()) begin
      fails++;
      $display("FAIL short_valid_cycles: got %0d, expected %0d", valid_cycles - vbase, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    bus.sample_ready = 1'b1;
    base = got_q.size();
    send_slot(1'b1, DW'($urandom), 6);
    send_slot(1'b0, DW'($urandom) | 24'h000001, 32);
    send_slot(1'b1, DW'($urandom) | 24'h000001, 32);
    send_slot(1'b0, DW'($urandom), 32);
    send_slot(1'b1, DW'($urandom), 11);
    repeat (5) @(posedge clock);
    model();
    check_frames("pre_reset", base);
    reset = 1'b1;
    #1;
    tests++;
    if (bus.data_left !== '0 || bus.data_right !== '0) begin
      fails++;
      $display("FAIL midreset_data: got %h, expected 0", {bus.data_left, bus.data_right});
    end
    tests++;
    if (bus.sample_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL midreset_flags: got valid=%b overrun=%b, expected 0/0", bus.sample_valid, bus.overrun);
    end
    slots.delete();
    i2s_bclk = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    base = got_q.size();
    send_slot(1'b1, DW'($urandom), 21);
    send_slot(1'b0, DW'($urandom), 32);
    send_slot(1'b1, DW'($urandom), 32);
    send_slot(1'b0, DW'($urandom), 3);
    repeat (10) @(posedge clock);
    model();
    check_frames("post_reset", base);
  endtask

  task automatic test_back_to_back();
    int              base, obase;
    logic [2*DW-1:0] fa, fb;
    slot_t           s;
    do_reset();
    bus.sample_ready = 1'b0;
    base  = got_q.size();
    obase = ovr_cycles;
    fa = {DW'($urandom), DW'($urandom)};
    fb = {DW'($urandom), DW'($urandom)};
    send_slot(1'b1, DW'($urandom), 6);
    send_slot(1'b0, fa[2*DW-1:DW], 32);
    send_slot(1'b1, fa[DW-1:0], 32);
    send_slot(1'b0, fb[2*DW-1:DW], 32);
    send_slot(1'b1, fb[DW-1:0], 32);
    @(negedge clock);
    tests++;
    if (bus.sample_valid !== 1'b1 || {bus.data_left, bus.data_right} !== fa) begin
      fails++;
      $display("FAIL b2b_first_held: got valid=%b %h, expected 1 %h", bus.sample_valid, {bus.data_left, bus.data_right}, fa);
    end
    // closing edge; B completes two system clocks after this rising edge
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_sdat = 1'b0;
    wait_half();
    i2s_bclk = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 bus.sample_ready = 1'b1;
    @(posedge clock);
    #1 bus.sample_ready = 1'b0;
    @(negedge clock);
    s.lr = 1'b0; s.len = 1; s.data = '0;
    slots.push_back(s);
    model();
    tests++;
    if (bus.sample_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b, expected 1", bus.sample_valid); end
    tests++;
    if ({bus.data_left, bus.data_right} !== fb) begin
      fails++;
      $display("FAIL b2b_new_loaded: got %h, expected %h", {bus.data_left, bus.data_right}, fb);
    end
    tests++;
    if (ovr_cycles !== obase) begin fails++; $display("FAIL b2b_overrun: got %0d pulses, expected 0", ovr_cycles - obase); end
    wait_half();
    bus.sample_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.sample_ready = 1'b0;
    check_frames("b2b", base);
  endtask

  task automatic test_sign();
    int base;
    do_reset();
    bus.sample_ready = 1'b1;
    base = got_q.size();
    send_slot(1'b1, DW'($urandom), 6);
    send_slot(1'b0, 24'h800000, 32);
    send_slot(1'b1, 24'h7FFFFF, 32);
    send_slot(1'b0, DW'($urandom), 32);
    send_slot(1'b1, DW'($urandom), 32);
    send_slot(1'b0, DW'($urandom), 3);
    repeat (10) @(posedge clock);
    model();
    check_frames("sign", base);
    tests++;
    if (got_q.size() <= base) begin
      fails++;
      $display("FAIL sign_extremes: got no frame, expected 800000/7fffff");
    end else if (got_q[base] !== {24'h800000, 24'h7FFFFF}) begin
      fails++;
      $display("FAIL sign_extremes: got %h, expected 8000007fffff", got_q[base]);
    end
  endtask

  initial begin
    bus.sample_ready = 1'b0;
    test_reset();
    test_stream();
    test_overrun();
    test_short_slot();
    test_reset_mid();
    test_back_to_back();
    test_sign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2s_sample_capture.md
I2S_SAMPLE_CAPTURE -- requirements
Module: i2s_sample_capture

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the bits captured per channel slot, MSB first.
REQ-002 The block SHALL have parameter MIN_SLOT_BITS, default 24, giving the minimum BCLK rising edges a slot must contain to be valid; it SHALL be >= DATA_WIDTH.
REQ-003 The block SHALL have port clock, input, 1, the system clock (CLOCK_50 domain).
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port i2s_bclk, input, 1, the asynchronous I2S bit clock.
REQ-006 The block SHALL have port i2s_lrck, input, 1, the asynchronous word select: 0 = left slot, 1 = right slot.
REQ-007 The block SHALL have port i2s_sdat, input, 1, the asynchronous serial data.
REQ-008 The block SHALL have port data_left, output, DATA_WIDTH, the left sample, two's complement.
REQ-009 The block SHALL have port data_right, output, DATA_WIDTH, the right sample, two's complement.
REQ-010 The block SHALL have port sample_valid, output, 1, indicating that a stereo frame is held on data_left/data_right.
REQ-011 The block SHALL have port sample_ready, input, 1, the consumer acceptance of the held frame.
REQ-012 The block SHALL have port overrun, output, 1, a one-cycle pulse when a completed frame is dropped.

Function
REQ-013 The block SHALL synchronise i2s_bclk, i2s_lrck and i2s_sdat each through two clock flops before any use.
REQ-014 A "bclk rise" SHALL be one clock cycle in which the synchronised bclk is 1 and was 0 on the previous cycle; all capture logic SHALL advance only on bclk rise.
REQ-015 On each bclk rise, the block SHALL compare the synchronised lrck with lrck_prev; a difference SHALL be a slot boundary.
REQ-016 On a slot boundary, the block SHALL reset bit_cnt to 0, set the current channel to the new lrck value, and discard the sdat bit sampled on that edge (I2S one-bit delay).
REQ-017 On a non-boundary bclk rise with bit_cnt < DATA_WIDTH, the block SHALL shift sdat into the LSB of the shift register.
REQ-018 On a non-boundary bclk rise, bit_cnt SHALL saturate at MIN_SLOT_BITS; bits beyond DATA_WIDTH SHALL be ignored.
REQ-019 The state machine SHALL have states UNLOCKED, LEFT and RIGHT.
REQ-020 After reset, the state SHALL be UNLOCKED.
REQ-021 UNLOCKED SHALL go to LEFT on the first boundary to lrck=0.
REQ-022 LEFT SHALL go to RIGHT on a boundary to lrck=1.
REQ-023 RIGHT SHALL go to LEFT on a boundary to lrck=0.
REQ-024 A slot SHALL be complete when a boundary arrives with bit_cnt >= MIN_SLOT_BITS.
REQ-025 A completed left slot SHALL be latched into an internal left_hold register.
REQ-026 A completed right slot, with a valid left_hold from the same frame, SHALL form a frame.
REQ-027 A slot ending with bit_cnt < MIN_SLOT_BITS SHALL be a short slot: the frame SHALL be discarded, the state SHALL return to UNLOCKED, and no overrun SHALL be reported.
REQ-028 Latency: sample_valid SHALL rise on the clock cycle after the bclk rise that detects the right-slot-ending boundary, and data_left/data_right SHALL update on that same cycle.
REQ-029 Handshake: while sample_valid=1, data_left and data_right SHALL be stable until the clock cycle on which sample_valid and sample_ready are both 1.
REQ-030 sample_valid SHALL clear after a transfer unless a new frame loads on the same cycle.
REQ-031 If a new frame completes while sample_valid=1 and sample_ready=0, the new frame SHALL be dropped, the held data SHALL be kept, and overrun SHALL pulse for one cycle.
REQ-032 If a new frame completes on the same cycle as a transfer, the new frame SHALL load, sample_valid SHALL stay 1, and no overrun SHALL occur.

Reset
REQ-033 While reset is high, all outputs SHALL be 0, the synchronisers, bit_cnt, shift register and left_hold SHALL be 0, and the state SHALL be UNLOCKED.
REQ-034 A reset asserted mid-slot or mid-frame SHALL abandon the partial frame; capture SHALL resume only after the next left-slot boundary.

Configuration
REQ-035 With macro I2S_CAPTURE_OVERRUN_CNT_EN defined, the block SHALL add output overrun_count, 8 bits, counting overrun pulses, saturating at 255, and reset to 0.
REQ-036 Without I2S_CAPTURE_OVERRUN_CNT_EN defined, the overrun_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 The bench SHALL apply reset, then 32-bit-slot I2S frames with left=24'h123456 and right=24'hFEDCBA, and sample_ready=1 -> each frame SHALL appear with sample_valid high for 1 cycle and the exact values; the first partial frame SHALL be discarded.
REQ-038 The bench SHALL hold sample_ready=0 across 2 frames -> the first frame SHALL be held, one overrun pulse SHALL occur, and overrun_count SHALL be 1 when the macro is defined.
REQ-039 The bench SHALL drive a 16-bit left slot -> no sample_valid SHALL occur for that frame, the state SHALL go to UNLOCKED, and the next full frame SHALL be captured correctly.
REQ-040 The bench SHALL assert reset during bit 10 of a right slot -> outputs SHALL be 0 immediately, and the next complete frame after the next left-slot boundary SHALL be correct.
REQ-041 The bench SHALL raise sample_ready on the same cycle a new frame completes -> the old frame SHALL transfer, the new frame SHALL load, sample_valid SHALL stay 1, and overrun SHALL be 0.
REQ-042 The bench SHALL send left=24'h800000 and right=24'h7FFFFF -> the sign bits SHALL be preserved exactly.
